// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the latch register-file controller: FSM encoding,
// default geometry and requester identifiers.
package reg_ctrl_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned REG_NUM_DEF = 4;
    localparam int unsigned ADDR_W_DEF  = 2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWSetup  = 3'd1,
        StWStrobe = 3'd2,
        StWHold   = 3'd3,
        StRRead   = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Grants are combinational and only issued
// while en_i is high; the last winner is remembered to break ties.
module rr_arbiter2
    import reg_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic last_q;

    always_comb begin
        gnt_a_o = en_i & req_a_i & (~req_b_i | (last_q == PORT_B));
        gnt_b_o = en_i & req_b_i & (~req_a_i | (last_q == PORT_A));
    end

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= PORT_B;
        end else if (gnt_a_o) begin
            last_q <= PORT_A;
        end else if (gnt_b_o) begin
            last_q <= PORT_B;
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Sequences a latch-based register file shared by two requesters. Latch
// enables and data come straight from flops with setup/strobe/hold phasing.
module reg_file_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned REG_NUM = REG_NUM_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_req,
    input  logic                      a_we,
    input  logic [ADDR_W-1:0]         a_addr,
    input  logic [DATA_W-1:0]         a_wdata,
    output logic                      a_ack,
    output logic [DATA_W-1:0]         a_rdata,
    input  logic                      b_req,
    input  logic                      b_we,
    input  logic [ADDR_W-1:0]         b_addr,
    input  logic [DATA_W-1:0]         b_wdata,
    output logic                      b_ack,
    output logic [DATA_W-1:0]         b_rdata,
    output logic [DATA_W-1:0]         lat_d,
    output logic [REG_NUM-1:0]        lat_e,
    input  logic [REG_NUM*DATA_W-1:0] lat_q,
    output logic                      busy
);

    state_e               state_q, state_d;
    logic                 port_q, port_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    lat_d_q, lat_d_d;
    logic [REG_NUM-1:0]   lat_e_q, lat_e_d;
    logic                 a_ack_q, a_ack_d;
    logic                 b_ack_q, b_ack_d;
    logic                 busy_q, busy_d;

    logic                 gnt_a, gnt_b;
    logic                 grant_we;
    logic [ADDR_W-1:0]    grant_addr;
    logic [DATA_W-1:0]    grant_wdata;
    logic [DATA_W-1:0]    words [REG_NUM];
    logic [DATA_W-1:0]    rd_word;

    rr_arbiter2 u_arb (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (state_q == StIdle),
        .req_a_i (a_req),
        .req_b_i (b_req),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b)
    );

    always_comb begin
        grant_we    = gnt_b ? b_we    : a_we;
        grant_addr  = gnt_b ? b_addr  : a_addr;
        grant_wdata = gnt_b ? b_wdata : a_wdata;
    end

    // Every output is computed one state ahead so it can be taken from a flop.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        addr_d  = addr_q;
        lat_d_d = lat_d_q;
        lat_e_d = '0;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_a || gnt_b) begin
                    port_d = gnt_b ? PORT_B : PORT_A;
                    addr_d = grant_addr;
                    if (grant_we) begin
                        state_d = StWSetup;
                        lat_d_d = grant_wdata;
                    end else begin
                        state_d = StRRead;
                        a_ack_d = gnt_a;
                        b_ack_d = gnt_b;
                    end
                end
            end
            StWSetup: begin
                state_d         = StWStrobe;
                lat_e_d[addr_q] = 1'b1;
            end
            StWStrobe: begin
                state_d = StWHold;
                a_ack_d = (port_q == PORT_A);
                b_ack_d = (port_q == PORT_B);
            end
            StWHold: state_d = StIdle;
            StRRead: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            port_q  <= PORT_B;
            addr_q  <= '0;
            lat_d_q <= '0;
            lat_e_q <= '0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            lat_d_q <= lat_d_d;
            lat_e_q <= lat_e_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar i = 0; i < REG_NUM; i++) begin : g_words
        assign words[i] = lat_q[i*DATA_W +: DATA_W];
    end

    assign rd_word = words[addr_q];

    always_comb begin
        a_rdata = '0;
        b_rdata = '0;
        if (state_q == StRRead) begin
            if (port_q == PORT_A) begin
                a_rdata = rd_word;
            end else begin
                b_rdata = rd_word;
            end
        end
    end

    assign lat_d = lat_d_q;
    assign lat_e = lat_e_q;
    assign a_ack = a_ack_q;
    assign b_ack = b_ack_q;
    assign busy  = busy_q;

endmodule
